// File: rtl/counter_pkg.sv
// Shared helpers for the counter: parameter legality and minimum-width computation.
// Optional feature macro used by this slice: COUNTER_SATURATE_EN.
package counter_pkg;

    // Smallest bit width able to represent max_value (at least 1).
    function automatic int min_width(input longint max_value);
        for (int i = 1; i < 63; i++) begin
            if ((64'sd1 <<< i) > max_value) begin
                return i;
            end
        end
        return 63;
    endfunction

    function automatic bit params_legal(
        input longint width,
        input longint reset_value,
        input longint increment,
        input longint max_value
    );
        return (width >= 1) &&
               (max_value >= 0) &&
               (increment >= 1) && (increment <= max_value) &&
               (reset_value >= 0) && (reset_value <= max_value) &&
               (min_width(max_value) <= width);
    endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational next-count and carry for one enabled counter step.
// COUNTER_SATURATE_EN selects clamping at max_value instead of modulo wrap.
module counter_step
    import counter_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [width-1:0] count,
    input  logic [width-1:0] increment,
    input  logic [width-1:0] max_value,
    output logic [width-1:0] next,
    output logic             carry
);

    // One extra bit so count + increment can never overflow before the compare.
    logic [width:0] sum;
    logic [width:0] limit;

    always_comb begin
        sum   = {1'b0, count} + {1'b0, increment};
        limit = {1'b0, max_value};
        next  = sum[width-1:0];
        carry = 1'b0;
        if (sum > limit) begin
            carry = 1'b1;
`ifdef COUNTER_SATURATE_EN
            next  = max_value;
`else
            next  = width'(sum - (limit + (width+1)'(1)));
`endif
        end
    end

endmodule

// File: rtl/counter.sv
// Parameterised up-counter: register and reset around counter_step.
// Define COUNTER_SATURATE_EN to clamp at max_value instead of wrapping.
module counter
    import counter_pkg::*;
#(
    parameter int width       = 8,
    parameter int reset_value = 0,
    parameter int increment   = 1,
    parameter int max_value   = 2**width - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [width-1:0] count,
    output logic             carry
);

    if (!params_legal(width, reset_value, increment, max_value)) begin : g_param_check
        $fatal(1, "counter: illegal parameters width=%0d reset_value=%0d increment=%0d max_value=%0d",
               width, reset_value, increment, max_value);
    end

    localparam logic [width-1:0] RESET_W = width'(reset_value);
    localparam logic [width-1:0] INC_W   = width'(increment);
    localparam logic [width-1:0] MAX_W   = width'(max_value);

    logic [width-1:0] step_next;
    logic             step_carry;

    counter_step #(
        .width(width)
    ) u_step (
        .count    (count),
        .increment(INC_W),
        .max_value(MAX_W),
        .next     (step_next),
        .carry    (step_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_W;
        end else if (enable) begin
            count <= step_next;
        end
    end

    // Carry only qualifies a step that will actually be taken this cycle.
    assign carry = enable & ~reset & step_carry;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter with width=4, reset_value=1, increment=3, max_value=15.
// Build with COUNTER_SATURATE_EN defined to exercise the saturating variant.
module tb_counter;

    localparam int W   = 4;
    localparam int RST = 1;
    localparam int INC = 3;
    localparam int MAX = 15;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [W-1:0] count;
    logic         carry;

    int errors = 0;
    int checks = 0;

    logic [W:0]   exp_q[$];
    logic [W:0]   exp;
    logic [W-1:0] model;

    counter #(
        .width      (W),
        .reset_value(RST),
        .increment  (INC),
        .max_value  (MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .count (count),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_next(input logic [W-1:0] c);
        int s;
        s = int'(c) + INC;
        if (s > MAX) begin
`ifdef COUNTER_SATURATE_EN
            return W'(MAX);
`else
            return W'(s - (MAX + 1));
`endif
        end
        return W'(s);
    endfunction

    // Drive one cycle's inputs, queue the expected {count, carry} seen before
    // the next edge, then advance the model past that edge.
    task automatic cycle(input logic en, input logic rst);
        logic c;
        @(posedge clk);
        #1;
        enable = en;
        reset  = rst;
        c = en && !rst && ((int'(model) + INC) > MAX);
        exp_q.push_back({model, c});
        @(negedge clk);
        if (rst)     model = W'(RST);
        else if (en) model = ref_next(model);
    endtask

    task automatic test_reset;
        cycle(1'b0, 1'b1);
        exp = exp_q.pop_front();
        checks++;
        if (carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_carry carry=%0b expected=0", carry);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if ({count, carry} !== exp || count !== 4'd1) begin
                errors++;
                $display("FAIL reset_hold[%0d] count=%0d carry=%0b expected count=1 carry=0", i, count, carry);
            end
        end
    endtask

`ifndef COUNTER_SATURATE_EN
    task automatic test_wrap;
        logic [W-1:0] tbl [20] = '{4'd4, 4'd7, 4'd10, 4'd13, 4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15,
                                   4'd2, 4'd5, 4'd8, 4'd11, 4'd14, 4'd1, 4'd4, 4'd7, 4'd10, 4'd13};
        logic [W-1:0] want;
        logic         want_c;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b0);
            exp = exp_q.pop_front();
            want   = (k == 0) ? 4'd1 : tbl[k-1];
            want_c = (want == 4'd13) || (want == 4'd14) || (want == 4'd15);
            checks++;
            if (count !== want || carry !== want_c || {count, carry} !== exp) begin
                errors++;
                $display("FAIL wrap[%0d] count=%0d carry=%0b expected count=%0d carry=%0b",
                         k, count, carry, want, want_c);
            end
        end
    endtask

    task automatic test_freeze;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (count !== 4'd13 || carry !== 1'b0 || {count, carry} !== exp) begin
                errors++;
                $display("FAIL freeze[%0d] count=%0d carry=%0b expected count=13 carry=0", i, count, carry);
            end
        end
    endtask
`else
    task automatic test_saturate;
        logic [W-1:0] tbl [8]  = '{4'd1, 4'd4, 4'd7, 4'd10, 4'd13, 4'd15, 4'd15, 4'd15};
        logic         ctbl [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        cycle(1'b0, 1'b1);
        exp = exp_q.pop_front();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (count !== tbl[k] || carry !== ctbl[k] || {count, carry} !== exp) begin
                errors++;
                $display("FAIL saturate[%0d] count=%0d carry=%0b expected count=%0d carry=%0b",
                         k, count, carry, tbl[k], ctbl[k]);
            end
        end
    endtask
`endif

    // Reset with enable high at count==10, then resume counting from 1.
    task automatic test_reset_during_count;
        cycle(1'b0, 1'b1);
        exp = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            exp = exp_q.pop_front();
        end
        cycle(1'b1, 1'b1);
        exp = exp_q.pop_front();
        checks++;
        if (count !== 4'd10 || carry !== 1'b0 || {count, carry} !== exp) begin
            errors++;
            $display("FAIL reset_mid_count count=%0d carry=%0b expected count=10 carry=0", count, carry);
        end
        cycle(1'b1, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (count !== 4'd1 || carry !== 1'b0 || {count, carry} !== exp) begin
            errors++;
            $display("FAIL reset_release count=%0d carry=%0b expected count=1 carry=0", count, carry);
        end
        cycle(1'b0, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (count !== 4'd4 || {count, carry} !== exp) begin
            errors++;
            $display("FAIL resume count=%0d carry=%0b expected count=4 carry=0", count, carry);
        end
    endtask

    // Reset at count==13 with enable high: the pending carry must be masked.
    task automatic test_reset_over_carry;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            exp = exp_q.pop_front();
        end
        cycle(1'b1, 1'b1);
        exp = exp_q.pop_front();
        checks++;
        if (count !== 4'd13 || carry !== 1'b0 || {count, carry} !== exp) begin
            errors++;
            $display("FAIL reset_over_carry count=%0d carry=%0b expected count=13 carry=0", count, carry);
        end
        cycle(1'b1, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (count !== 4'd1 || carry !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_over_carry count=%0d carry=%0b expected count=1 carry=0", count, carry);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        model  = W'(RST);
        test_reset;
`ifndef COUNTER_SATURATE_EN
        test_wrap;
        test_freeze;
`else
        test_saturate;
`endif
        test_reset_during_count;
        test_reset_over_carry;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter width, default 8: bit width of count.
REQ-002 Parameter reset_value, default 0: count value loaded by reset.
REQ-003 Parameter increment, default 1: amount added per enabled cycle.
REQ-004 Parameter max_value, default 2**width-1: highest legal count value.
REQ-005 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-006 Port reset  input  1: synchronous, active-high reset.
REQ-007 Port enable  input  1: when high, count advances this cycle.
REQ-008 Port count  output  width: registered current count.
REQ-009 Port carry  output  1: combinational; high in the cycle whose enabled step exceeds max_value.

Function
REQ-010 Legal parameters SHALL satisfy 1 <= increment <= max_value, reset_value <= max_value, max_value <= 2**width-1; an illegal set SHALL fail elaboration with a fatal message.
REQ-011 enable low: count SHALL hold its value, and carry SHALL be 0.
REQ-012 enable high: the sum s = count + increment SHALL be computed in width+1 bits so that no intermediate overflow occurs.
REQ-013 enable high, s <= max_value: next count SHALL be s, and carry SHALL be 0.
REQ-014 enable high, s > max_value, default build: next count SHALL be s - (max_value+1), wrapping modulo max_value+1; carry SHALL be 1 in that cycle.
REQ-015 Latency: count SHALL reflect an enabled step on the rising edge after enable is sampled high; carry SHALL be valid in the same cycle as the enable it qualifies.
REQ-016 Exact hit (s == max_value): no wrap; count SHALL become max_value, and carry SHALL be 0.
REQ-017 increment == max_value+1 is illegal per REQ-010; increment == max_value SHALL alternate correctly through the wrap path.

Reset
REQ-018 reset high at a rising edge: count SHALL load reset_value, regardless of enable.
REQ-019 reset SHALL override enable; carry SHALL be 0 while reset is high.
REQ-020 Reset mid-count SHALL discard the current value with no residual carry; counting resumes from reset_value on the first enabled cycle after release.

Configuration
REQ-021 Macro COUNTER_SATURATE_EN not defined: the wrapping behaviour of REQ-014 SHALL apply.
REQ-022 Macro COUNTER_SATURATE_EN defined: when enable is high and s > max_value, next count SHALL be max_value, and carry SHALL be 1 (including repeated cycles while held at max_value).

Structure
REQ-023 Package counter_pkg SHALL hold the parameter-legality check function, used by REQ-010.
REQ-024 Package counter_pkg SHALL hold a helper returning the minimum width for a given max_value.
REQ-025 The next-state/carry computation SHALL be one combinational sub-module, counter_step (inputs count, increment, max_value; outputs next, carry); counter SHALL own only the register and reset logic.

Verification (width=4, reset_value=1, increment=3, max_value=15)
REQ-026 Scenario "reset then hold": reset 1 cycle, then enable=0 for 10 cycles -> count==1 throughout; carry==0.
REQ-027 Scenario "wrap sequence": enable=1 from count=1 -> count 4,7,10,13,0,3,6,9,12,15,2,5,8,11,14,1,4,7,10,13 on successive edges; carry==1 exactly when count is 13, 15 or 14 with enable high.
REQ-028 Scenario "freeze after run": after 20 enabled cycles, enable=0 for 10 cycles -> count stays 13; carry==0.
REQ-029 Scenario "reset during count": assert reset with enable=1 while count==10 -> next count==1, carry==0 during reset.
REQ-030 Scenario "saturate build": with COUNTER_SATURATE_EN defined, enable=1 from count=1 -> count 4,7,10,13,15,15; carry==1 from the cycle at 13 onward.
REQ-031 Scenario "illegal parameters": elaborate with increment=0 or reset_value=16 -> fatal elaboration error.
